word_to_ast_stream: RTL and testbench
=====================================

WORD_TO_AST_STREAM -- requirements
Module: word_to_ast_stream

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, bits per symbol.
REQ-002 SHALL have parameter MAX_DATA_SYMBOLS, default 6, maximum symbols per input word.
REQ-003 SHALL have parameter AST_SOURCE_SYMBOLS, default 4, symbols per output beat (S).
REQ-004 SHALL have parameter AST_SOURCE_ORDER, default 1, where 1 means first symbol in the MSB lane and 0 means first symbol in lane 0.
REQ-005 SHALL have parameter BUF_DEPTH, default 4, word buffer depth, a power of two of at least 2.
REQ-006 SHALL have derived widths LEN_W = $clog2(MAX_DATA_SYMBOLS+1) and EMPTY_W = max(1, $clog2(S)).
REQ-007 SHALL have port clk_i  in  1  the single clock.
REQ-008 SHALL have port arst_n_i  in  1  reset, asynchronous and active-low.
REQ-009 SHALL have port data_i  in  MAX_DATA_SYMBOLS x BYTE_W  word to stream; symbol 0 is at [BYTE_W-1:0].
REQ-010 SHALL have port data_len_i  in  LEN_W  number of valid symbols, legal range 1..MAX_DATA_SYMBOLS.
REQ-011 SHALL have port data_valid_i  in  1  word offered.
REQ-012 SHALL have port ready_o  out  1  buffer can accept a word.
REQ-013 SHALL have the AST source ports: ast_source_data_o (out, S x BYTE_W), ast_source_valid_o (out, 1), ast_source_ready_i (in, 1), ast_source_startofpacket_o (out, 1), ast_source_endofpacket_o (out, 1), ast_source_empty_o (out, EMPTY_W).
REQ-014 SHALL have port err_cnt_o  out  16  count of dropped illegal words.

Function
REQ-015 A word SHALL be accepted at a rising edge where data_valid_i && ready_o; ready_o SHALL be 1 exactly when the buffer is not full.
REQ-016 Each accepted word SHALL become one AST packet of ceil(len/S) beats, in acceptance order.
REQ-017 Beat k SHALL carry symbols k*S .. k*S+S-1, placed in lanes according to AST_SOURCE_ORDER; unused lanes SHALL be driven 0.
REQ-018 startofpacket SHALL be asserted on beat 0 only, and endofpacket on the last beat only; a 1-beat packet SHALL assert both.
REQ-019 ast_source_empty_o SHALL be 0 on non-last beats and ceil(len/S)*S - len on the last beat.
REQ-020 While valid && !ready, all source outputs SHALL be held stable.
REQ-021 Latency SHALL be: a word accepted at edge N into an empty buffer is presented valid in the cycle after N.
REQ-022 Packets SHALL be sent back-to-back: after an eop handshake, the next packet's sop SHALL be valid in the next cycle if the buffer is non-empty, with no idle beat.
REQ-023 A write and a read in the same cycle SHALL be supported; the occupancy is unchanged in that case.
REQ-024 The beat counter SHALL be internal, reset to 0 at eop handshake, and sized for ceil(MAX_DATA_SYMBOLS/S) beats.
REQ-025 ast_source_valid_o SHALL be 1 exactly when the buffer is non-empty.

Reset
REQ-026 arst_n_i low SHALL immediately force: buffer empty, beat counter 0, err_cnt_o 0, and all source outputs 0.
REQ-027 ready_o SHALL be 0 while in reset and 1 from the first edge after deassertion.
REQ-028 A reset taken mid-packet SHALL discard that packet and all buffered words; no eop is emitted.

Configuration
REQ-029 With WORD_TO_AST_LEN_CHECK_EN defined, a word handshaken with data_len_i == 0 or > MAX_DATA_SYMBOLS SHALL be dropped (not buffered), and err_cnt_o SHALL increment, saturating at 0xFFFF.
REQ-030 Without WORD_TO_AST_LEN_CHECK_EN, illegal lengths SHALL be treated as MAX_DATA_SYMBOLS and err_cnt_o SHALL be tied to 0.

Structure
REQ-031 Package word_to_ast_pkg SHALL hold the LEN_W/EMPTY_W/beat-count functions and the buffered-entry struct {data, len}.
REQ-032 Buffering SHALL be the sub-module word_to_ast_fifo (sync FIFO, async active-low reset, full/empty flags).

Verification (BYTE_W=8, MAX=6, S=4, ORDER=1, DEPTH=4)
REQ-033 Scenario 1: len=6, data 0x060504030201, sink always ready -> beat 0x01020304 with sop=1, empty=0; then 0x05060000 with eop=1, empty=2.
REQ-034 Scenario 2: len=3, ORDER=0 -> single beat 0x00030201 with sop=eop=1, empty=1.
REQ-035 Scenario 3: sink ready=0, push 5 words -> ready_o=0 after the 4th; release ready -> 4 packets back-to-back with no gap, in order.
REQ-036 Scenario 4: random ast_source_ready_i toggling -> data, sop, eop and empty held stable during stalls; symbol scoreboard matches.
REQ-037 Scenario 5: assert arst_n_i between beat 1 and beat 2 -> outputs 0 at once; after release the next word streams from sop.
REQ-038 Scenario 6 (macro defined): len=0, then len=7 -> no packet emitted, err_cnt_o=2; without the macro, len=7 emits 6 symbols.

Source files
------------

// File: rtl/word_to_ast_pkg.sv
// Shared width helpers, lane-order encoding and buffered-entry layout for word_to_ast_stream.
package word_to_ast_pkg;

    typedef enum logic {
        ORDER_LANE0     = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } ast_order_e;

    localparam int DEF_BYTE_W        = 8;
    localparam int DEF_MAX_SYMBOLS   = 6;
    localparam int DEF_LEN_W         = $clog2(DEF_MAX_SYMBOLS + 1);

    function automatic int len_w(input int max_symbols);
        return $clog2(max_symbols + 1);
    endfunction

    function automatic int empty_w(input int symbols);
        return (symbols > 1) ? $clog2(symbols) : 1;
    endfunction

    function automatic int beat_count(input int len, input int symbols);
        return (len + symbols - 1) / symbols;
    endfunction

    function automatic int beat_w(input int max_symbols, input int symbols);
        int nb;
        nb = beat_count(max_symbols, symbols);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Entry layout at the default geometry; the top rebuilds the same {data, len} shape at its own parameters.
    typedef struct packed {
        logic [DEF_MAX_SYMBOLS*DEF_BYTE_W-1:0] data;
        logic [DEF_LEN_W-1:0]                 len;
    } word_entry_t;

endpackage

// File: rtl/word_to_ast_stream_if.sv
// Avalon-ST style source bus: symbols, valid/ready, packet delimiters and empty count.
interface word_to_ast_stream_if #(
    parameter int BYTE_W  = 8,
    parameter int SYMBOLS = 4,
    parameter int EMPTY_W = 2
);
    logic [SYMBOLS*BYTE_W-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      startofpacket;
    logic                      endofpacket;
    logic [EMPTY_W-1:0]        empty;

    modport source (output data, valid, startofpacket, endofpacket, empty, input ready);
    modport sink   (input data, valid, startofpacket, endofpacket, empty, output ready);
endinterface

// File: rtl/word_to_ast_fifo.sv
// Sync FIFO with combinational head read; write visible at the head one cycle later.
// Full/empty derive from a registered count; simultaneous read and write keeps occupancy.
module word_to_ast_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_ok, rd_ok;

    assign full_o    = (cnt_q == DEPTH[AW:0]);
    assign empty_o   = (cnt_q == '0);
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/word_to_ast_stream.sv
// Buffers words and streams each as one AST packet; first beat valid the cycle after accept, ready_o = buffer not full.
// Outputs hold while the sink stalls. WORD_TO_AST_LEN_CHECK_EN drops and counts illegal lengths instead of clamping.
module word_to_ast_stream
    import word_to_ast_pkg::*;
#(
    parameter int  BYTE_W             = 8,
    parameter int  MAX_DATA_SYMBOLS   = 6,
    parameter int  AST_SOURCE_SYMBOLS = 4,
    parameter int  AST_SOURCE_ORDER   = 1,
    parameter int  BUF_DEPTH          = 4,
    localparam int LEN_W              = len_w(MAX_DATA_SYMBOLS),
    localparam int EMPTY_W            = empty_w(AST_SOURCE_SYMBOLS)
) (
    input  logic                             clk_i,
    input  logic                             arst_n_i,
    input  logic [MAX_DATA_SYMBOLS*BYTE_W-1:0] data_i,
    input  logic [LEN_W-1:0]                 data_len_i,
    input  logic                             data_valid_i,
    output logic                             ready_o,
    word_to_ast_stream_if.source             ast_source,
    output logic [15:0]                      err_cnt_o
);
    localparam int S         = AST_SOURCE_SYMBOLS;
    localparam int DATA_W    = MAX_DATA_SYMBOLS * BYTE_W;
    localparam int LANE_W    = S * BYTE_W;
    localparam int MAX_BEATS = beat_count(MAX_DATA_SYMBOLS, S);
    localparam int BEAT_W    = beat_w(MAX_DATA_SYMBOLS, S);
    localparam int PAD_W     = MAX_BEATS * LANE_W;
    localparam ast_order_e ORDER = ast_order_e'(AST_SOURCE_ORDER[0]);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } entry_t;

    entry_t             wr_entry, head;
    logic               accept, push, pop, len_legal;
    logic               fifo_full, fifo_empty, rdy_en_q;
    logic               src_vld, src_hs, last_beat;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [PAD_W-1:0]   head_shifted;
    logic [LANE_W-1:0]  lanes;
    logic [EMPTY_W-1:0] empty_val;
    int                 nbeats;

    assign len_legal = (data_len_i != '0) && (int'(data_len_i) <= MAX_DATA_SYMBOLS);
    assign accept    = data_valid_i && ready_o;
    assign ready_o   = rdy_en_q && !fifo_full;
    assign wr_entry.data = data_i;

`ifdef WORD_TO_AST_LEN_CHECK_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    assign push          = accept && len_legal;
    assign wr_entry.len  = data_len_i;
    assign err_cnt_o     = err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !len_legal && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) err_cnt_q <= '0;
        else           err_cnt_q <= err_cnt_d;
    end
`else
    assign push          = accept;
    assign wr_entry.len  = len_legal ? data_len_i : LEN_W'(MAX_DATA_SYMBOLS);
    assign err_cnt_o     = '0;
`endif

    word_to_ast_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .wr_en_i   (push),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign src_vld = !fifo_empty;
    assign src_hs  = src_vld && ast_source.ready;
    assign pop     = src_hs && last_beat;

    always_comb begin
        nbeats       = beat_count(int'(head.len), S);
        last_beat    = (int'(beat_q) == nbeats - 1);
        empty_val    = last_beat ? EMPTY_W'(nbeats * S - int'(head.len)) : '0;
        head_shifted = PAD_W'(head.data) >> (int'(beat_q) * LANE_W);
        lanes        = '0;
        // Symbols past the word length stay zero even though the buffer holds stale bytes there.
        for (int j = 0; j < S; j++) begin
            if (int'(beat_q) * S + j < int'(head.len)) begin
                if (ORDER == ORDER_MSB_FIRST)
                    lanes[(S-1-j)*BYTE_W +: BYTE_W] = head_shifted[j*BYTE_W +: BYTE_W];
                else
                    lanes[j*BYTE_W +: BYTE_W] = head_shifted[j*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (src_hs) beat_d = last_beat ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            beat_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Everything is gated by valid so reset and an empty buffer present an all-zero bus.
    assign ast_source.valid         = src_vld;
    assign ast_source.data          = src_vld ? lanes : '0;
    assign ast_source.startofpacket = src_vld && (beat_q == '0);
    assign ast_source.endofpacket   = src_vld && last_beat;
    assign ast_source.empty         = src_vld ? empty_val : '0;

endmodule

// File: tb/tb_word_to_ast_stream.sv
// Directed bench for word_to_ast_stream: MSB-first and lane-0 instances, stalls, reset and length handling.
module tb_word_to_ast_stream;

    logic        clk;
    logic        arst_n;
    logic [47:0] d0_data, d1_data;
    logic [2:0]  d0_len, d1_len;
    logic        d0_vld, d1_vld, d0_rdy, d1_rdy;
    logic [15:0] d0_err, d1_err;
    logic [36:0] obs0, obs1;
    logic [36:0] bp_exp [6];
    int          errors = 0;
    int          checks = 0;

    word_to_ast_stream_if #(.BYTE_W(8), .SYMBOLS(4), .EMPTY_W(2)) src0 ();
    word_to_ast_stream_if #(.BYTE_W(8), .SYMBOLS(4), .EMPTY_W(2)) src1 ();

    word_to_ast_stream #(
        .BYTE_W(8), .MAX_DATA_SYMBOLS(6), .AST_SOURCE_SYMBOLS(4), .AST_SOURCE_ORDER(1), .BUF_DEPTH(4)
    ) dut0 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d0_data), .data_len_i(d0_len),
        .data_valid_i(d0_vld), .ready_o(d0_rdy), .ast_source(src0), .err_cnt_o(d0_err)
    );

    word_to_ast_stream #(
        .BYTE_W(8), .MAX_DATA_SYMBOLS(6), .AST_SOURCE_SYMBOLS(4), .AST_SOURCE_ORDER(0), .BUF_DEPTH(4)
    ) dut1 (
        .clk_i(clk), .arst_n_i(arst_n), .data_i(d1_data), .data_len_i(d1_len),
        .data_valid_i(d1_vld), .ready_o(d1_rdy), .ast_source(src1), .err_cnt_o(d1_err)
    );

    // Packed view: {valid, sop, eop, empty[1:0], data[31:0]}
    assign obs0 = {src0.valid, src0.startofpacket, src0.endofpacket, src0.empty, src0.data};
    assign obs1 = {src1.valid, src1.startofpacket, src1.endofpacket, src1.empty, src1.data};

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (d0_rdy !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", d0_rdy); end
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL reset_bus0: got %h want 0", obs0); end
        checks++; if (obs1 !== 37'h0) begin errors++; $display("FAIL reset_bus1: got %h want 0", obs1); end
        checks++; if (d0_err !== 16'h0) begin errors++; $display("FAIL reset_err: got %h want 0", d0_err); end
        arst_n = 1'b1;
        @(negedge clk);
        checks++; if ({d0_rdy, d1_rdy} !== 2'b11) begin errors++; $display("FAIL ready_after_reset: got %b want 11", {d0_rdy, d1_rdy}); end
    endtask

    task automatic test_len6();
        src0.ready = 1'b1;
        @(negedge clk);
        d0_data = 48'h060504030201; d0_len = 3'd6; d0_vld = 1'b1;
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== {1'b1, 1'b1, 1'b0, 2'd0, 32'h01020304}) begin errors++; $display("FAIL len6_beat0: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 2'd0, 32'h01020304}); end
        @(negedge clk);
        checks++; if (obs0 !== {1'b1, 1'b0, 1'b1, 2'd2, 32'h05060000}) begin errors++; $display("FAIL len6_beat1: got %h want %h", obs0, {1'b1, 1'b0, 1'b1, 2'd2, 32'h05060000}); end
        @(negedge clk);
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL len6_idle: got %h want 0", obs0); end
    endtask

    task automatic test_order0();
        src1.ready = 1'b1;
        @(negedge clk);
        d1_data = 48'h000000030201; d1_len = 3'd3; d1_vld = 1'b1;
        @(negedge clk);
        d1_vld = 1'b0;
        checks++; if (obs1 !== {1'b1, 1'b1, 1'b1, 2'd1, 32'h00030201}) begin errors++; $display("FAIL order0_beat: got %h want %h", obs1, {1'b1, 1'b1, 1'b1, 2'd1, 32'h00030201}); end
        @(negedge clk);
        checks++; if (obs1 !== 37'h0) begin errors++; $display("FAIL order0_idle: got %h want 0", obs1); end
    endtask

    task automatic test_backpressure();
        logic [47:0] wd [5];
        logic [2:0]  wl [5];
        wd = '{48'h001514131211, 48'h000024232221, 48'h363534333231, 48'h000000000041, 48'h000000005251};
        wl = '{3'd5, 3'd4, 3'd6, 3'd1, 3'd2};
        bp_exp[0] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h11121314};
        bp_exp[1] = {1'b1, 1'b0, 1'b1, 2'd3, 32'h15000000};
        bp_exp[2] = {1'b1, 1'b1, 1'b1, 2'd0, 32'h21222324};
        bp_exp[3] = {1'b1, 1'b1, 1'b0, 2'd0, 32'h31323334};
        bp_exp[4] = {1'b1, 1'b0, 1'b1, 2'd2, 32'h35360000};
        bp_exp[5] = {1'b1, 1'b1, 1'b1, 2'd3, 32'h41000000};
        src0.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (d0_rdy !== (i < 4)) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, d0_rdy, (i < 4)); end
            d0_data = wd[i]; d0_len = wl[i]; d0_vld = 1'b1;
        end
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== bp_exp[0]) begin errors++; $display("FAIL bp_stalled_head: got %h want %h", obs0, bp_exp[0]); end
        src0.ready = 1'b1;
        for (int b = 0; b < 6; b++) begin
            checks++; if (obs0 !== bp_exp[b]) begin errors++; $display("FAIL bp_beat[%0d]: got %h want %h", b, obs0, bp_exp[b]); end
            @(negedge clk);
        end
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL bp_drained: got %h want 0", obs0); end
    endtask

    task automatic test_random_stall();
        logic [7:0]  sbq [$];
        int          lens_q [$];
        int          lens [6];
        int          wi, rem, cyc, cnt;
        bit          stalled, sop_e;
        logic [36:0] prev, exp;
        logic [47:0] wd;
        lens = '{6, 3, 5, 2, 4, 1};
        wi = 0; rem = 0; cyc = 0; stalled = 0; prev = '0;
        while (cyc < 400 && !(wi == 6 && lens_q.size() == 0 && rem == 0)) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++; if (obs0 !== prev) begin errors++; $display("FAIL stall_hold: got %h want %h", obs0, prev); end
            end
            src0.ready = 1'($urandom_range(0, 1));
            if (wi < 6) begin
                for (int k = 0; k < 6; k++) wd[k*8 +: 8] = {4'(wi + 1), 4'(k)};
                d0_data = wd; d0_len = 3'(lens[wi]); d0_vld = 1'b1;
            end else begin
                d0_vld = 1'b0;
            end
            if (d0_vld && d0_rdy) begin
                for (int k = 0; k < lens[wi]; k++) sbq.push_back(wd[k*8 +: 8]);
                lens_q.push_back(lens[wi]);
                wi++;
            end
            if (src0.valid && src0.ready) begin
                sop_e = (rem == 0);
                if (rem == 0 && lens_q.size() > 0) rem = lens_q.pop_front();
                cnt = (rem > 4) ? 4 : rem;
                exp = '0;
                exp[36] = 1'b1;
                exp[35] = sop_e;
                exp[34] = (rem <= 4);
                exp[33:32] = (rem <= 4) ? 2'(4 - rem) : 2'd0;
                for (int j = 0; j < 4; j++)
                    if (j < cnt && sbq.size() > 0) exp[(3-j)*8 +: 8] = sbq.pop_front();
                rem = rem - cnt;
                checks++; if (obs0 !== exp) begin errors++; $display("FAIL rand_beat: got %h want %h", obs0, exp); end
            end
            stalled = src0.valid && !src0.ready;
            prev = obs0;
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL rand_timeout: pushed %0d of 6 words, %0d symbols left", wi, sbq.size()); end
        d0_vld = 1'b0;
        src0.ready = 1'b1;
        @(negedge clk);
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL rand_drained: got %h want 0", obs0); end
    endtask

    task automatic test_reset_mid();
        src0.ready = 1'b1;
        @(negedge clk);
        d0_data = 48'hC6C5C4C3C2C1; d0_len = 3'd6; d0_vld = 1'b1;
        @(negedge clk);
        d0_data = 48'h00000000D2D1; d0_len = 3'd2;
        checks++; if (obs0 !== {1'b1, 1'b1, 1'b0, 2'd0, 32'hC1C2C3C4}) begin errors++; $display("FAIL mid_beat0: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 2'd0, 32'hC1C2C3C4}); end
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== {1'b1, 1'b0, 1'b1, 2'd2, 32'hC5C60000}) begin errors++; $display("FAIL mid_beat1: got %h want %h", obs0, {1'b1, 1'b0, 1'b1, 2'd2, 32'hC5C60000}); end
        arst_n = 1'b0;
        #1;
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL mid_reset_bus: got %h want 0", obs0); end
        checks++; if (d0_rdy !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", d0_rdy); end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        checks++; if ({d0_rdy, obs0} !== {1'b1, 37'h0}) begin errors++; $display("FAIL mid_after_release: got rdy=%b bus=%h want rdy=1 bus=0", d0_rdy, obs0); end
        d0_data = 48'h00000000BBAA; d0_len = 3'd2; d0_vld = 1'b1;
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== {1'b1, 1'b1, 1'b1, 2'd2, 32'hAABB0000}) begin errors++; $display("FAIL mid_restart: got %h want %h", obs0, {1'b1, 1'b1, 1'b1, 2'd2, 32'hAABB0000}); end
        @(negedge clk);
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL mid_idle: got %h want 0", obs0); end
    endtask

    task automatic test_len_check();
        src0.ready = 1'b1;
`ifdef WORD_TO_AST_LEN_CHECK_EN
        @(negedge clk);
        d0_data = 48'h111111111111; d0_len = 3'd0; d0_vld = 1'b1;
        @(negedge clk);
        d0_len = 3'd7;
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL lenchk_no_packet: got %h want 0", obs0); end
        checks++; if (d0_err !== 16'd2) begin errors++; $display("FAIL lenchk_err_cnt: got %0d want 2", d0_err); end
        @(negedge clk);
        checks++; if (obs0 !== 37'h0) begin errors++; $display("FAIL lenchk_still_idle: got %h want 0", obs0); end
`else
        @(negedge clk);
        d0_data = 48'h666564636261; d0_len = 3'd7; d0_vld = 1'b1;
        @(negedge clk);
        d0_vld = 1'b0;
        checks++; if (obs0 !== {1'b1, 1'b1, 1'b0, 2'd0, 32'h61626364}) begin errors++; $display("FAIL len7_beat0: got %h want %h", obs0, {1'b1, 1'b1, 1'b0, 2'd0, 32'h61626364}); end
        @(negedge clk);
        checks++; if (obs0 !== {1'b1, 1'b0, 1'b1, 2'd2, 32'h65660000}) begin errors++; $display("FAIL len7_beat1: got %h want %h", obs0, {1'b1, 1'b0, 1'b1, 2'd2, 32'h65660000}); end
        checks++; if (d0_err !== 16'd0) begin errors++; $display("FAIL len7_err_cnt: got %0d want 0", d0_err); end
`endif
    endtask

    initial begin
        clk = 1'b0; arst_n = 1'b0;
        d0_data = '0; d0_len = '0; d0_vld = 1'b0;
        d1_data = '0; d1_len = '0; d1_vld = 1'b0;
        src0.ready = 1'b0; src1.ready = 1'b0;
        test_reset();
        test_len6();
        test_order0();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        test_len_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
